// File: rtl/nabp_filtered_ram_rotator_if.sv
// rtl/nabp_filtered_ram_rotator_if.sv - signal bundle around the filtered-RAM rotation controller
//
// Purpose: carries the host handshake, the per-buffer swappable fill/read
// steering, the per-lane data/angle outputs and the status outputs of
// nabp_filtered_ram_rotator. clk and reset_n are not part of the bundle.
//
// Parameters: NUM_LANES, S_WIDTH, DATA_WIDTH, ANGLE_WIDTH (buffer count NB = NUM_LANES+1).
// Modports:
//   master - the rotator: reads host/swappable/lane requests, drives steering and status
//   slave  - the environment: host filter path, swappables and processing lanes

interface nabp_filtered_ram_rotator_if #(
  parameter int NUM_LANES   = 2,
  parameter int S_WIDTH     = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 9
) ();

  localparam int NB = NUM_LANES + 1;

  // host filter path
  logic [ANGLE_WIDTH-1:0]           hs_angle;
  logic                             hs_has_next_angle;
  logic                             hs_next_angle_ack;
  logic                             hs_next_angle;
  logic [S_WIDTH-1:0]               hs_s_val;

  // swappable buffers
  logic [NB-1:0]                    sw_fill_kick;
  logic [NB-1:0]                    sw_fill_done;
  logic [NB*S_WIDTH-1:0]            sw_hs_s_val;
  logic [NB*S_WIDTH-1:0]            sw_pr_s_val;
  logic [NB*DATA_WIDTH-1:0]         sw_pr_val;

  // processing lanes
  logic [NUM_LANES*S_WIDTH-1:0]     pr_s_val;
  logic [NUM_LANES*DATA_WIDTH-1:0]  pr_val;
  logic [NUM_LANES*ANGLE_WIDTH-1:0] pr_angle;
  logic [NUM_LANES-1:0]             pr_angle_valid;
  logic                             pr_next_angle;
  logic                             pr_next_angle_ack;
  logic                             pr_done;

  // status
  logic                             busy;
  logic [31:0]                      stall_cnt;

  modport master (
    input  hs_angle, hs_has_next_angle, hs_next_angle_ack,
    input  sw_fill_done, sw_hs_s_val, sw_pr_val,
    input  pr_s_val, pr_next_angle, pr_done,
    output hs_next_angle, hs_s_val,
    output sw_fill_kick, sw_pr_s_val,
    output pr_val, pr_angle, pr_angle_valid, pr_next_angle_ack,
    output busy, stall_cnt
  );

  modport slave (
    output hs_angle, hs_has_next_angle, hs_next_angle_ack,
    output sw_fill_done, sw_hs_s_val, sw_pr_val,
    output pr_s_val, pr_next_angle, pr_done,
    input  hs_next_angle, hs_s_val,
    input  sw_fill_kick, sw_pr_s_val,
    input  pr_val, pr_angle, pr_angle_valid, pr_next_angle_ack,
    input  busy, stall_cnt
  );

endinterface

// File: rtl/nabp_filtered_ram_rotator.sv
// rtl/nabp_filtered_ram_rotator.sv - ring rotation controller for filtered-projection buffers
//
// Purpose: schedules NB = NUM_LANES+1 external filtered-RAM swappables in a
// ring. One buffer is filled from the host/FIR path while NUM_LANES buffers
// feed the processing lanes. Owns the rotation pointer, the per-buffer fill
// kicks, all address/data steering, the per-lane angle/valid pipeline and an
// IDLE/PRIME/RUN/DRAIN sequencer.
//
// Ports:
//   clk      in  single clock, all state on its rising edge
//   reset_n  in  asynchronous active-low reset
//   bus      nabp_filtered_ram_rotator_if.master
//            host:   hs_angle, hs_has_next_angle, hs_next_angle_ack -> hs_next_angle, hs_s_val
//            bufs:   sw_fill_done, sw_hs_s_val, sw_pr_val -> sw_fill_kick, sw_pr_s_val
//            lanes:  pr_s_val, pr_next_angle, pr_done -> pr_val, pr_angle, pr_angle_valid,
//                    pr_next_angle_ack
//            status: busy, stall_cnt
//
// Build option:
//   NABP_ROTATOR_STALL_COUNT_EN - defined: stall_cnt saturating-counts RUN
//   cycles where the lanes ask to rotate but the fill buffer is not done.
//   Undefined: stall_cnt is tied to 0.

module nabp_filtered_ram_rotator #(
  parameter int NUM_LANES   = 2,
  parameter int S_WIDTH     = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 9
) (
  input logic                         clk,
  input logic                         reset_n,
  nabp_filtered_ram_rotator_if.master bus
);

  localparam int NB    = NUM_LANES + 1;
  localparam int SEL_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NB - 1);
  localparam logic [SEL_W-1:0] P_LAST   = SEL_W'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [SEL_W-1:0]       p_q, p_d;

  // ang_q/vld_q hold the angle of the buffer currently being filled; the
  // lanes hold the angles of the buffers they are reading.
  logic [ANGLE_WIDTH-1:0] ang_q;
  logic                   vld_q;
  logic [ANGLE_WIDTH-1:0] lane_ang_q [NUM_LANES];
  logic [NUM_LANES-1:0]   lane_vld_q;

  logic                   rotate;
  logic                   hs_next;
  logic                   fill_done;
  logic                   any_valid;

  int                     fill_idx;
  int                     kick_idx;
  int                     lane_buf [NUM_LANES];

  logic [S_WIDTH-1:0]               hs_s_val_c;
  logic [NB*S_WIDTH-1:0]            sw_pr_s_val_c;
  logic [NUM_LANES*DATA_WIDTH-1:0]  pr_val_c;
  logic [NUM_LANES*ANGLE_WIDTH-1:0] pr_angle_c;
  logic [NB-1:0]                    kick_c;

  // x mod NB for x in [0, 2*NB)
  function automatic int wrap_nb(input int x);
    return (x >= NB) ? x - NB : x;
  endfunction

  // Ring indices: the fill buffer trails lane 0 by one slot, and the kick
  // targets the buffer that becomes the fill buffer after this rotate.
  always_comb begin
    fill_idx = wrap_nb(NB - int'(sel_q));
    kick_idx = NB - 1 - int'(sel_q);
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_buf[k] = wrap_nb(k + 1 + NB - int'(sel_q));
    end
  end

  always_comb begin
    fill_done = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (b == fill_idx) fill_done = bus.sw_fill_done[b];
    end
  end

  assign any_valid = |lane_vld_q;

  // Sequencer: next state, rotate and host request
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    rotate  = 1'b0;
    hs_next = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rotate = bus.hs_next_angle_ack;
        if (rotate) begin
          state_d = ST_PRIME;
          p_d     = '0;
        end
      end
      ST_PRIME: begin
        hs_next = fill_done;
        rotate  = fill_done & bus.hs_next_angle_ack;
        if (rotate) begin
          p_d = p_q + 1'b1;
          if (p_q == P_LAST) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // With no further angle the last rotate goes ahead without an ack.
        if (fill_done && bus.pr_next_angle) begin
          hs_next = bus.hs_has_next_angle;
          rotate  = !bus.hs_has_next_angle | bus.hs_next_angle_ack;
        end
        if (rotate && !bus.hs_has_next_angle) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        rotate = bus.pr_next_angle & any_valid;
        if (!any_valid && bus.pr_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_d = sel_q;
    if (rotate) sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
  end

  // Address/data steering; the fill buffer's read address stays 0.
  always_comb begin
    hs_s_val_c    = '0;
    sw_pr_s_val_c = '0;
    pr_val_c      = '0;
    kick_c        = '0;
    for (int b = 0; b < NB; b++) begin
      if (b == fill_idx) hs_s_val_c = bus.sw_hs_s_val[b*S_WIDTH +: S_WIDTH];
      kick_c[b] = rotate && (b == kick_idx);
      for (int k = 0; k < NUM_LANES; k++) begin
        if (lane_buf[k] == b) begin
          sw_pr_s_val_c[b*S_WIDTH +: S_WIDTH]   = bus.pr_s_val[k*S_WIDTH +: S_WIDTH];
          pr_val_c[k*DATA_WIDTH +: DATA_WIDTH] = bus.sw_pr_val[b*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    pr_angle_c = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      pr_angle_c[k*ANGLE_WIDTH +: ANGLE_WIDTH] = lane_ang_q[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      p_q        <= '0;
      ang_q      <= '0;
      vld_q      <= 1'b0;
      lane_vld_q <= '0;
      for (int k = 0; k < NUM_LANES; k++) lane_ang_q[k] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      p_q     <= p_d;
      if (rotate) begin
        ang_q         <= bus.hs_angle;
        vld_q         <= bus.hs_has_next_angle;
        lane_ang_q[0] <= ang_q;
        lane_vld_q[0] <= vld_q;
        for (int k = 1; k < NUM_LANES; k++) begin
          lane_ang_q[k] <= lane_ang_q[k-1];
          lane_vld_q[k] <= lane_vld_q[k-1];
        end
      end
    end
  end

`ifdef NABP_ROTATOR_STALL_COUNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (state_q == ST_RUN && bus.pr_next_angle && !fill_done && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif

  assign bus.hs_next_angle     = hs_next;
  assign bus.hs_s_val          = hs_s_val_c;
  assign bus.sw_fill_kick      = kick_c;
  assign bus.sw_pr_s_val       = sw_pr_s_val_c;
  assign bus.pr_val            = pr_val_c;
  assign bus.pr_angle          = pr_angle_c;
  assign bus.pr_angle_valid    = lane_vld_q;
  assign bus.pr_next_angle_ack = rotate;
  assign bus.busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nabp_filtered_ram_rotator.sv
// tb/tb_nabp_filtered_ram_rotator.sv - bench for nabp_filtered_ram_rotator

module tb_nabp_filtered_ram_rotator;

  localparam int SW = 10;
  localparam int DW = 16;
  localparam int AW = 9;

`ifdef NABP_ROTATOR_STALL_COUNT_EN
  localparam int EXP_STALL = 4;
`else
  localparam int EXP_STALL = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- main DUT (2 lanes)
  nabp_filtered_ram_rotator_if #(.NUM_LANES(2), .S_WIDTH(SW), .DATA_WIDTH(DW), .ANGLE_WIDTH(AW)) bus2();
  nabp_filtered_ram_rotator #(.NUM_LANES(2), .S_WIDTH(SW), .DATA_WIDTH(DW), .ANGLE_WIDTH(AW)) dut (
    .clk(clk), .reset_n(rst_n), .bus(bus2)
  );

  typedef struct {
    logic          ack;
    logic [2:0]    fdone;
    logic          pnext;
    logic          hasn;
    logic [AW-1:0] ang;
    logic          pdone;
    logic          rot;
    logic [2:0]    kick;
    logic          hsn;
    logic          busy;
    logic [1:0]    vld;
    logic [2*AW-1:0] pang;
  } vec_t;

  vec_t tbl [19];

  task automatic zero_inputs2();
    bus2.hs_angle = '0;
    bus2.hs_has_next_angle = 1'b0;
    bus2.hs_next_angle_ack = 1'b0;
    bus2.sw_fill_done = '0;
    bus2.sw_hs_s_val = '0;
    bus2.sw_pr_val = '0;
    bus2.pr_s_val = '0;
    bus2.pr_next_angle = 1'b0;
    bus2.pr_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, bus2.busy, 0);
    check({tag, " pr_angle_valid"}, bus2.pr_angle_valid, 0);
    check({tag, " pr_angle"}, bus2.pr_angle, 0);
    check({tag, " sw_fill_kick"}, bus2.sw_fill_kick, 0);
    check({tag, " hs_next_angle"}, bus2.hs_next_angle, 0);
    check({tag, " pr_next_angle_ack"}, bus2.pr_next_angle_ack, 0);
    check({tag, " stall_cnt"}, bus2.stall_cnt, 0);
    check({tag, " hs_s_val"}, bus2.hs_s_val, 0);
    check({tag, " pr_val"}, bus2.pr_val, 0);
    check({tag, " sw_pr_s_val"}, bus2.sw_pr_s_val, 0);
  endtask

  // ---------------------------------------------------------------- random sweeps (1 and 4 lanes)
  for (genvar g = 0; g < 2; g++) begin : g_sw
    localparam int L  = (g == 0) ? 1 : 4;
    localparam int NB = L + 1;

    logic srst_n;
    bit   done;

    nabp_filtered_ram_rotator_if #(.NUM_LANES(L), .S_WIDTH(SW), .DATA_WIDTH(DW), .ANGLE_WIDTH(AW)) sbus();
    nabp_filtered_ram_rotator #(.NUM_LANES(L), .S_WIDTH(SW), .DATA_WIDTH(DW), .ANGLE_WIDTH(AW)) sdut (
      .clk(clk), .reset_n(srst_n), .bus(sbus)
    );

    initial begin
      int sel, phase, primes, run_rot, cyc, fill, bsel;
      int hq[$];
      logic a, pn, fd, rot, hsn;
      logic [AW-1:0] ang;
      logic [NB-1:0] ek;
      logic [SW-1:0] es;
      done = 1'b0;
      sel = 0; phase = 0; primes = 0; run_rot = 0; cyc = 0;
      srst_n = 1'b0;
      sbus.hs_angle = '0;
      sbus.hs_has_next_angle = 1'b1;
      sbus.hs_next_angle_ack = 1'b0;
      sbus.sw_fill_done = '0;
      sbus.sw_hs_s_val = '0;
      sbus.sw_pr_val = '0;
      sbus.pr_s_val = '0;
      sbus.pr_next_angle = 1'b0;
      sbus.pr_done = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      srst_n = 1'b1;
      while (run_rot < 2*NB && cyc < 3000) begin
        @(negedge clk);
        cyc++;
        for (int b = 0; b < NB; b++) begin
          sbus.sw_pr_val[b*DW +: DW]   = DW'($urandom);
          sbus.sw_hs_s_val[b*SW +: SW] = SW'($urandom);
          sbus.sw_fill_done[b]         = ($urandom_range(3, 0) != 0);
        end
        for (int k = 0; k < L; k++) sbus.pr_s_val[k*SW +: SW] = SW'($urandom);
        a   = ($urandom_range(3, 0) != 0);
        pn  = ($urandom_range(3, 0) != 0);
        ang = AW'($urandom);
        sbus.hs_next_angle_ack = a;
        sbus.pr_next_angle     = pn;
        sbus.hs_angle          = ang;
        #1;
        fill = (NB - sel) % NB;
        fd   = sbus.sw_fill_done[fill];
        case (phase)
          0:       begin rot = a;           hsn = 1'b0;    end
          1:       begin rot = fd & a;      hsn = fd;      end
          default: begin rot = fd & pn & a; hsn = fd & pn; end
        endcase
        ek = '0;
        if (rot) ek[NB-1-sel] = 1'b1;
        check($sformatf("L%0d rotate", L), sbus.pr_next_angle_ack, rot);
        check($sformatf("L%0d hs_next_angle", L), sbus.hs_next_angle, hsn);
        check($sformatf("L%0d sw_fill_kick", L), sbus.sw_fill_kick, ek);
        check($sformatf("L%0d hs_s_val", L), sbus.hs_s_val, sbus.sw_hs_s_val[fill*SW +: SW]);
        for (int k = 0; k < L; k++) begin
          bsel = (k + 1 - sel + NB) % NB;
          check($sformatf("L%0d lane%0d pr_val sel%0d", L, k, sel),
                sbus.pr_val[k*DW +: DW], sbus.sw_pr_val[bsel*DW +: DW]);
        end
        for (int b = 0; b < NB; b++) begin
          es = '0;
          for (int k = 0; k < L; k++) if ((k + 1 - sel + NB) % NB == b) es = sbus.pr_s_val[k*SW +: SW];
          check($sformatf("L%0d buf%0d sw_pr_s_val", L, b), sbus.sw_pr_s_val[b*SW +: SW], es);
        end
        @(posedge clk);
        #1;
        if (rot) begin
          sel = (sel + 1) % NB;
          hq.push_front(int'(ang));
          if (phase == 0) begin
            phase = 1; primes = 0;
          end else if (phase == 1) begin
            primes++;
            if (primes == L) phase = 2;
          end else begin
            run_rot++;
          end
        end
        check($sformatf("L%0d busy", L), sbus.busy, phase != 0);
        for (int k = 0; k < L; k++) begin
          check($sformatf("L%0d lane%0d valid", L, k), sbus.pr_angle_valid[k], hq.size() > k + 1);
          check($sformatf("L%0d lane%0d angle", L, k), sbus.pr_angle[k*AW +: AW],
                (hq.size() > k + 1) ? hq[k+1] : 0);
        end
      end
      check($sformatf("L%0d run rotations reached", L), run_rot >= 2*NB, 1);
      done = 1'b1;
    end
  end

  // ---------------------------------------------------------------- directed test
  initial begin
    // ack, fdone, pnext, hasn, ang, pdone | rot, kick, hsn | busy, vld, pang{lane1,lane0}
    tbl[0]  = '{0, 3'b000, 0, 0, 0, 0,  0, 3'b000, 0,  0, 2'b00, {9'd0, 9'd0}};
    tbl[1]  = '{1, 3'b000, 0, 1, 5, 0,  1, 3'b100, 0,  1, 2'b00, {9'd0, 9'd0}};
    tbl[2]  = '{1, 3'b000, 0, 1, 6, 0,  0, 3'b000, 0,  1, 2'b00, {9'd0, 9'd0}};
    tbl[3]  = '{0, 3'b111, 0, 1, 6, 0,  0, 3'b000, 1,  1, 2'b00, {9'd0, 9'd0}};
    tbl[4]  = '{1, 3'b111, 0, 1, 6, 0,  1, 3'b010, 1,  1, 2'b01, {9'd0, 9'd5}};
    tbl[5]  = '{1, 3'b111, 0, 1, 7, 0,  1, 3'b001, 1,  1, 2'b11, {9'd5, 9'd6}};
    tbl[6]  = '{1, 3'b000, 1, 1, 8, 0,  0, 3'b000, 0,  1, 2'b11, {9'd5, 9'd6}};
    tbl[7]  = '{1, 3'b000, 1, 1, 8, 0,  0, 3'b000, 0,  1, 2'b11, {9'd5, 9'd6}};
    tbl[8]  = '{1, 3'b000, 1, 1, 8, 0,  0, 3'b000, 0,  1, 2'b11, {9'd5, 9'd6}};
    tbl[9]  = '{1, 3'b000, 1, 1, 8, 0,  0, 3'b000, 0,  1, 2'b11, {9'd5, 9'd6}};
    tbl[10] = '{0, 3'b111, 1, 1, 8, 0,  0, 3'b000, 1,  1, 2'b11, {9'd5, 9'd6}};
    tbl[11] = '{1, 3'b111, 1, 1, 8, 0,  1, 3'b100, 1,  1, 2'b11, {9'd6, 9'd7}};
    tbl[12] = '{0, 3'b111, 1, 0, 9, 0,  1, 3'b010, 0,  1, 2'b11, {9'd7, 9'd8}};
    tbl[13] = '{0, 3'b000, 0, 0, 0, 0,  0, 3'b000, 0,  1, 2'b11, {9'd7, 9'd8}};
    tbl[14] = '{0, 3'b000, 1, 0, 0, 0,  1, 3'b001, 0,  1, 2'b10, {9'd8, 9'd9}};
    tbl[15] = '{0, 3'b000, 1, 0, 0, 0,  1, 3'b100, 0,  1, 2'b00, {9'd9, 9'd0}};
    tbl[16] = '{0, 3'b000, 1, 0, 0, 0,  0, 3'b000, 0,  1, 2'b00, {9'd9, 9'd0}};
    tbl[17] = '{0, 3'b000, 0, 0, 0, 1,  0, 3'b000, 0,  0, 2'b00, {9'd9, 9'd0}};
    tbl[18] = '{0, 3'b000, 0, 0, 0, 0,  0, 3'b000, 0,  0, 2'b00, {9'd9, 9'd0}};

    rst_n = 1'b0;
    zero_inputs2();
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      bus2.hs_next_angle_ack = tbl[i].ack;
      bus2.sw_fill_done      = tbl[i].fdone;
      bus2.pr_next_angle     = tbl[i].pnext;
      bus2.hs_has_next_angle = tbl[i].hasn;
      bus2.hs_angle          = tbl[i].ang;
      bus2.pr_done           = tbl[i].pdone;
      #1;
      check($sformatf("v%0d rotate", i), bus2.pr_next_angle_ack, tbl[i].rot);
      check($sformatf("v%0d sw_fill_kick", i), bus2.sw_fill_kick, tbl[i].kick);
      check($sformatf("v%0d hs_next_angle", i), bus2.hs_next_angle, tbl[i].hsn);
      @(posedge clk);
      #1;
      check($sformatf("v%0d busy", i), bus2.busy, tbl[i].busy);
      check($sformatf("v%0d pr_angle_valid", i), bus2.pr_angle_valid, tbl[i].vld);
      check($sformatf("v%0d pr_angle", i), bus2.pr_angle, tbl[i].pang);
    end
    check("stall_cnt after run stalls", bus2.stall_cnt, 64'(EXP_STALL));

    // Mid-RUN asynchronous reset, then restart from sel=0.
    @(negedge clk);
    bus2.hs_next_angle_ack = 1'b1;
    bus2.hs_has_next_angle = 1'b1;
    bus2.sw_fill_done      = 3'b111;
    bus2.hs_angle          = 9'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus2.hs_next_angle_ack = 1'b0;
    bus2.pr_next_angle     = 1'b1;
    #1;
    check("run hs_next_angle", bus2.hs_next_angle, 1);
    check("run busy", bus2.busy, 1);
    check("run pr_angle_valid", bus2.pr_angle_valid, 2'b11);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset busy", bus2.busy, 0);
    check("async reset hs_next_angle", bus2.hs_next_angle, 0);
    check("async reset pr_angle_valid", bus2.pr_angle_valid, 0);
    check("async reset pr_angle", bus2.pr_angle, 0);
    check("async reset sw_fill_kick", bus2.sw_fill_kick, 0);
    check("async reset stall_cnt", bus2.stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post reset no kick", bus2.sw_fill_kick, 0);
    check("post reset idle hs_next_angle", bus2.hs_next_angle, 0);
    bus2.hs_next_angle_ack = 1'b1;
    #1;
    check("restart kick from sel0", bus2.sw_fill_kick, 3'b100);
    check("restart rotate", bus2.pr_next_angle_ack, 1);
    @(posedge clk);
    #1;
    check("restart busy", bus2.busy, 1);
    @(negedge clk);
    zero_inputs2();

    for (int c = 0; c < 5000 && !(g_sw[0].done && g_sw[1].done); c++) @(posedge clk);
    check("sweeps finished", {g_sw[0].done, g_sw[1].done}, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
